if_stage: RTL and testbench

- Instruction-fetch stage for the 5-stage MIPS core, placed directly upstream of decode.
- Owns the fetch PC and drives the synchronous instruction memory, which returns data one cycle after a request.
- Buffers fetched words in a small FIFO and hands each {inst, pc, pc+4} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from downstream, discarding every wrong-path word.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/if_fifo.sv | 77 +++++++
 rtl/if_stage.sv | 188 ++++++++++++++++++
 tb/tb_if_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the instruction-fetch stage and its buffer:
//   - RESET_PC_DEF  : default fetch address after reset
//   - NOP           : instruction word used when no real fetch occurred
//   - BOOT/RUN/HOLD : fetch FSM encodings, plus the enum built from them
//   - fetch_entry_t : one buffered fetch {inst, pc, misalign}
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    typedef enum logic [1:0] {
        ST_BOOT = BOOT,
        ST_RUN  = RUN,
        ST_HOLD = HOLD
    } fetch_state_e;

    localparam int INST_W  = 32;
    localparam int PC_W    = 32;
    localparam int MIS_W   = 1;
    localparam int ENTRY_W = INST_W + PC_W + MIS_W;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic [MIS_W-1:0]  misalign;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// -----------------------------------------------------------------------------
// if_fifo
// DEPTH-entry synchronous FIFO of fetch entries. The head is read
// combinationally from the storage array. Push and pop in the same cycle are
// allowed even when full. Flush empties the buffer and wins over push/pop.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_flush         discard all entries
//   i_push          write i_push_data (ignored when full without a pop)
//   i_push_data     entry to append
//   i_pop           remove head (ignored when empty)
//   o_head          current head entry (meaningful only when !o_empty)
//   o_empty         no entries buffered
//   o_count         number of entries buffered (0..DEPTH)
// -----------------------------------------------------------------------------
module if_fifo
    import cpu_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    output fetch_entry_t o_head,
    output logic         o_empty,
    output logic [AW:0]  o_count
);

    fetch_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_flush;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the 5-stage MIPS core. Owns the fetch PC, drives
// the synchronous instruction memory (data returns one cycle after imem_en),
// buffers returned words in if_fifo and presents {inst, pc, pc+4} to decode
// over a valid/ready handshake. A redirect flushes all wrong-path state.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_en/addr      memory read request, word address fpc[IMEM_AW+1:2]
//   imem_rdata        memory data, valid the cycle after imem_en
//   redirect_valid/pc flush and restart fetch at redirect_pc
//   id_valid/ready    handshake to decode
//   id_inst/pc/pc_4   head entry (held at last value while empty)
//   id_misalign       head entry came from a misaligned redirect
// Optional feature macro: IF_MISALIGN_TRAP_EN
//   defined   : redirect_pc[1:0] is kept; a misaligned fetch skips the memory,
//               queues a NOP with misalign=1 and halts fetch until a redirect
//   undefined : redirect_pc[1:0] is forced to 0 and id_misalign is tied to 0
// -----------------------------------------------------------------------------
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IMEM_AW  = 9,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [31:0]        id_inst,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc_4,
    output logic               id_misalign
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e r_state;
    logic [31:0]  r_fpc;
    logic [31:0]  r_pending_pc;
    logic         r_inflight;
    logic         r_pend_mis;   // the in-flight slot is a misalign trap, not a memory read
    logic         r_halt;       // fetch stopped by a misalign trap until the next redirect

    logic [31:0]  r_last_inst;
    logic [31:0]  r_last_pc;
    logic [31:0]  r_last_pc4;

    fetch_entry_t w_head;
    fetch_entry_t w_push_data;
    logic         w_empty;
    logic [CW-1:0] w_count;
    logic         w_pop;
    logic         w_push;
    logic         w_space;
    logic         w_fetch;
    logic         w_fetch_mis;
    logic [31:0]  w_redir_pc;
    logic [CW:0]  w_occ_sum;
    logic [CW:0]  w_limit;

`ifdef IF_MISALIGN_TRAP_EN
    logic r_last_mis;
    assign w_fetch_mis = (r_fpc[1:0] != 2'b00);
    assign w_redir_pc  = redirect_pc;
`else
    logic w_unused_bits;
    assign w_fetch_mis   = 1'b0;
    assign w_redir_pc    = {redirect_pc[31:2], 2'b00};
    assign w_unused_bits = ^{redirect_pc[1:0], w_head.misalign};
`endif

    assign id_valid = ~w_empty;
    assign w_pop    = id_valid & id_ready;

    // Issue only if the slot claimed now still fits once this cycle's pop leaves:
    // occupancy + inflight - pop < DEPTH, rearranged to avoid underflow.
    assign w_occ_sum = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_limit   = (CW+1)'(DEPTH) + {{CW{1'b0}}, w_pop};
    assign w_space   = (w_occ_sum < w_limit);

    assign w_fetch   = (r_state == ST_RUN) & ~redirect_valid & w_space;
    assign imem_en   = w_fetch & ~w_fetch_mis;
    assign imem_addr = r_fpc[IMEM_AW+1:2];

    // A redirect drops the response that is returning this cycle.
    assign w_push             = r_inflight & ~redirect_valid;
    assign w_push_data.inst   = r_pend_mis ? NOP : imem_rdata;
    assign w_push_data.pc     = r_pending_pc;
    assign w_push_data.misalign = r_pend_mis;

    if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BOOT;
            r_fpc        <= RESET_PC;
            r_pending_pc <= '0;
            r_inflight   <= 1'b0;
            r_pend_mis   <= 1'b0;
            r_halt       <= 1'b0;
        end else if (redirect_valid) begin
            r_state    <= ST_RUN;
            r_fpc      <= w_redir_pc;
            r_inflight <= 1'b0;
            r_pend_mis <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state    <= ST_RUN;
                    r_inflight <= 1'b0;
                end
                ST_RUN: begin
                    if (w_fetch) begin
                        r_inflight   <= 1'b1;
                        r_pending_pc <= r_fpc;
                        r_pend_mis   <= w_fetch_mis;
                        if (w_fetch_mis) begin
                            r_state <= ST_HOLD;
                            r_halt  <= 1'b1;
                        end else begin
                            r_fpc <= r_fpc + 32'd4;
                        end
                    end else begin
                        // Only reason not to fetch in RUN here is a full buffer.
                        r_inflight <= 1'b0;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    r_inflight <= 1'b0;
                    if (w_pop && !r_halt) r_state <= ST_RUN;
                end
                default: begin
                    r_state    <= ST_BOOT;
                    r_inflight <= 1'b0;
                end
            endcase
        end
    end

    // Last presented head, shown to decode whenever the buffer is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_inst <= '0;
            r_last_pc   <= '0;
            r_last_pc4  <= '0;
        end else if (id_valid) begin
            r_last_inst <= w_head.inst;
            r_last_pc   <= w_head.pc;
            r_last_pc4  <= w_head.pc + 32'd4;
        end
    end

    assign id_inst = id_valid ? w_head.inst : r_last_inst;
    assign id_pc   = id_valid ? w_head.pc : r_last_pc;
    assign id_pc_4 = id_valid ? (w_head.pc + 32'd4) : r_last_pc4;

`ifdef IF_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_last_mis <= 1'b0;
        else if (id_valid) r_last_mis <= w_head.misalign;
    end
    assign id_misalign = id_valid ? w_head.misalign : r_last_mis;
`else
    assign id_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage (DEPTH=2, IMEM_AW=9). The instruction memory
// model returns 32'h1000_0000 + word address one cycle after imem_en.
// Honours IF_MISALIGN_TRAP_EN for the misaligned-redirect step.
// -----------------------------------------------------------------------------
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_en;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_4;
    logic        id_misalign;

    int checks = 0;
    int errors = 0;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (9),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc_4        (id_pc_4),
        .id_misalign    (id_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial imem_rdata = 32'h0;
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);
    end

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        return 32'h1000_0000 + {23'b0, pc[10:2]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Head must be valid now with the given pc; it is consumed at the next edge.
    task automatic xfer_now(input logic [31:0] pc);
        chk("xfer_valid", 32'(id_valid), 32'd1);
        chk("xfer_pc", id_pc, pc);
        chk("xfer_inst", id_inst, exp_inst(pc));
        chk("xfer_pc4", id_pc_4, pc + 32'd4);
        chk("xfer_mis", 32'(id_misalign), 32'd0);
        $display("xfer pc=0x%08h inst=0x%08h pc4=0x%08h", id_pc, id_inst, id_pc_4);
        tick();
    endtask

    task automatic wait_head(input logic [31:0] pc);
        int n = 0;
        while (id_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("head_valid", 32'(id_valid), 32'd1);
        chk("head_pc", id_pc, pc);
    endtask

    task automatic get_word(input logic [31:0] pc);
        wait_head(pc);
        xfer_now(pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_inst", id_inst, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_pc4", id_pc_4, 32'd0);
        chk("rst_en", 32'(imem_en), 32'd0);
        chk("rst_mis", 32'(id_misalign), 32'd0);

        // Release away from the clock edge; BOOT issues nothing
        rst_n = 1'b1;
        #1 chk("boot_no_req", 32'(imem_en), 32'd0);
        tick();
        chk("lat_c1_valid", 32'(id_valid), 32'd0);
        chk("run_req", 32'(imem_en), 32'd1);
        chk("run_addr", 32'(imem_addr), 32'd0);
        tick();
        chk("lat_c2_valid", 32'(id_valid), 32'd0);
        tick();

        // Stream at one word per cycle, starting exactly on the third edge
        for (int k = 0; k < 6; k++) xfer_now(32'(k * 4));

        // Back-pressure: buffer fills, no requests, head stable
        id_ready = 1'b0;
        #1 chk("stall_no_req", 32'(imem_en), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(id_valid), 32'd1);
            chk("stall_pc", id_pc, 32'd24);
            chk("stall_inst", id_inst, exp_inst(32'd24));
            chk("stall_no_req", 32'(imem_en), 32'd0);
        end
        id_ready = 1'b1;
        for (int k = 6; k < 11; k++) get_word(32'(k * 4));

        // Redirect while the buffer is full and decode is stalled
        id_ready = 1'b0;
        repeat (3) tick();
        chk("pre_redir_pc", id_pc, 32'd44);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1 chk("redir_no_req", 32'(imem_en), 32'd0);
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        chk("redir_c1_valid", 32'(id_valid), 32'd0);
        chk("redir_hold_pc", id_pc, 32'd44);
        #1 chk("redir_req", 32'(imem_en), 32'd1);
        chk("redir_addr", 32'(imem_addr), 32'h40);
        tick();
        chk("redir_c2_valid", 32'(id_valid), 32'd0);
        tick();
        xfer_now(32'h100);
        get_word(32'h104);

        // Redirect coinciding with a pop, then a second redirect next cycle
        wait_head(32'h108);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_pc = 32'h0000_0200;
        chk("dbl_c1_valid", 32'(id_valid), 32'd0);
        chk("dbl_hold_pc", id_pc, 32'h108);
        tick();
        redirect_valid = 1'b0;
        chk("dbl_c2_valid", 32'(id_valid), 32'd0);
        tick();
        chk("dbl_c3_valid", 32'(id_valid), 32'd0);
        tick();
        xfer_now(32'h200);
        get_word(32'h204);

        // PC wrap at the top of the address space, memory alias to word 0x1FF
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1 chk("wrap_req", 32'(imem_en), 32'd1);
        chk("wrap_addr", 32'(imem_addr), 32'h1FF);
        tick();
        tick();
        xfer_now(32'hFFFF_FFFC);
        get_word(32'h0000_0000);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        #1 chk("mis_no_req", 32'(imem_en), 32'd0);
        tick();
        tick();
        chk("mis_valid", 32'(id_valid), 32'd1);
        chk("mis_flag", 32'(id_misalign), 32'd1);
        chk("mis_inst", id_inst, 32'd0);
        chk("mis_pc", id_pc, 32'h102);
        $display("xfer pc=0x%08h inst=0x%08h misalign=%0d", id_pc, id_inst, id_misalign);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("mis_halt_valid", 32'(id_valid), 32'd0);
            chk("mis_halt_req", 32'(imem_en), 32'd0);
            chk("mis_halt_pc", id_pc, 32'h102);
            tick();
        end
`else
        #1 chk("mis_req", 32'(imem_en), 32'd1);
        chk("mis_addr", 32'(imem_addr), 32'h40);
        tick();
        tick();
        xfer_now(32'h100);
        get_word(32'h104);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
